// File: rtl/hd_pkg.sv
// Shared types for the pipelined accumulate tree: sum type, sideband bundle,
// and the tree depth helper.
package hd_pkg;

    localparam int SUM_W = 16;

    typedef logic signed [SUM_W-1:0] sum_t;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
        sum_t bias;
    } sb_t;

    function automatic int levels(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/N_bit_adder.sv
// Plain N-bit two's complement adder; the carry out is dropped so sums wrap.
module N_bit_adder #(
    parameter int N = 16
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/adder_tree_stage.sv
// One registered level of the reduction tree: N_IN operands in, N_IN/2 out.
module adder_tree_stage #(
    parameter int N_IN = 2,
    parameter int W    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [N_IN*W-1:0]     d_in,
    output logic [(N_IN/2)*W-1:0] d_out
);

    localparam int N_OUT = N_IN / 2;

    logic [N_OUT*W-1:0] pair_sum;
    logic [N_OUT*W-1:0] sum_d;
    logic [N_OUT*W-1:0] sum_q;

    for (genvar i = 0; i < N_OUT; i++) begin : g_pair
        N_bit_adder #(.N(W)) u_add (
            .a   (d_in[(2*i)*W +: W]),
            .b   (d_in[(2*i+1)*W +: W]),
            .sum (pair_sum[i*W +: W])
        );
    end

    always_comb begin
        sum_d = pair_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else if (en) begin
            sum_q <= sum_d;
        end
    end

    assign d_out = sum_q;

endmodule

// File: rtl/pipelined_accum_tree.sv
// Registered adder tree plus accumulate stage with first/last framing.
// Define ACCUM_TREE_SAT_EN to saturate the accumulator instead of wrapping.
module pipelined_accum_tree
    import hd_pkg::*;
#(
    parameter int INPUT_WIDTH = 8,
    parameter int DIM_WIDTH   = 16,
    parameter int FTSIZE      = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [FTSIZE*INPUT_WIDTH-1:0] inputs,
    input  logic [DIM_WIDTH-1:0]          last_in,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_first,
    input  logic                          in_last,
    output logic [DIM_WIDTH-1:0]          out,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          seq_err
);

    localparam int LEVELS = levels(FTSIZE);
    localparam int DW     = DIM_WIDTH;
    localparam int IW     = INPUT_WIDTH;

    logic                  en;
    logic [FTSIZE*DW-1:0]  ext;
    logic signed [DW-1:0]  tree_sum;
    sb_t                   sb_d [LEVELS];
    sb_t                   sb_q [LEVELS];
    sb_t                   s;
    logic signed [DW-1:0]  base;
    logic signed [DW-1:0]  acc_new;
    logic signed [DW-1:0]  acc_d, acc_q;
    logic                  open_d, open_q;
    logic [DW-1:0]         out_d, out_q;
    logic                  out_valid_d, out_valid_q;
    logic                  seq_err_d, seq_err_q;

    // A held result stalls the whole pipe, so nothing can be overwritten.
    assign en       = !(out_valid_q && !out_ready);
    assign in_ready = en;

    always_comb begin
        ext = '0;
        for (int i = 0; i < FTSIZE; i++) begin
            ext[i*DW +: DW] = {{(DW-IW){inputs[i*IW+IW-1]}}, inputs[i*IW +: IW]};
        end
    end

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int NI = FTSIZE >> k;
        logic [NI*DW-1:0]     d_in;
        logic [(NI/2)*DW-1:0] d_out;
        if (k == 0) begin : g_first
            assign d_in = ext;
        end else begin : g_next
            assign d_in = g_lvl[k-1].d_out;
        end
        adder_tree_stage #(.N_IN(NI), .W(DW)) u_stage (
            .clk   (clk),
            .rst_n (reset),
            .en    (en),
            .d_in  (d_in),
            .d_out (d_out)
        );
    end

    assign tree_sum = g_lvl[LEVELS-1].d_out;

    always_comb begin
        sb_d[0].valid = in_valid;
        sb_d[0].first = in_first;
        sb_d[0].last  = in_last;
        sb_d[0].bias  = sum_t'(last_in);
        for (int i = 1; i < LEVELS; i++) begin
            sb_d[i] = sb_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LEVELS; i++) begin
                sb_q[i] <= '0;
            end
        end else if (en) begin
            for (int i = 0; i < LEVELS; i++) begin
                sb_q[i] <= sb_d[i];
            end
        end
    end

    assign s = sb_q[LEVELS-1];

    always_comb begin
        base = s.first ? s.bias : acc_q;
`ifdef ACCUM_TREE_SAT_EN
        begin
            logic [DW:0] wide;
            wide = {base[DW-1], base} + {tree_sum[DW-1], tree_sum};
            if (wide[DW] != wide[DW-1]) begin
                acc_new = wide[DW] ? {1'b1, {(DW-1){1'b0}}}
                                   : {1'b0, {(DW-1){1'b1}}};
            end else begin
                acc_new = wide[DW-1:0];
            end
        end
`else
        acc_new = base + tree_sum;
`endif
    end

    always_comb begin
        acc_d       = acc_q;
        open_d      = open_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        seq_err_d   = 1'b0;
        if (en) begin
            out_valid_d = s.valid && s.last;
            if (s.valid) begin
                acc_d     = acc_new;
                // Error when first meets an open vector, or a continuation finds none.
                seq_err_d = (s.first == open_q);
                open_d    = s.last ? 1'b0 : (s.first ? 1'b1 : open_q);
                if (s.last) begin
                    out_d = acc_new;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q       <= '0;
            open_q      <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            seq_err_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            open_q      <= open_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            seq_err_q   <= seq_err_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign seq_err   = seq_err_q;

endmodule

// File: tb/tb_pipelined_accum_tree.sv
// Directed bench for pipelined_accum_tree (honours ACCUM_TREE_SAT_EN).
module tb_pipelined_accum_tree;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [127:0] inputs = '0;
    logic [15:0]  last_in = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         in_first = 1'b0;
    logic         in_last = 1'b0;
    logic [15:0]  out;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic         seq_err;

    int n_cmp = 0;
    int n_bad = 0;
    int n_err = 0;
    logic [15:0] got[$];

    pipelined_accum_tree dut (
        .clk       (clk),
        .reset     (reset),
        .inputs    (inputs),
        .last_in   (last_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_first  (in_first),
        .in_last   (in_last),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .seq_err   (seq_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset && out_valid && out_ready) got.push_back(out);
        if (seq_err) n_err++;
    end

    typedef struct {
        logic [127:0] d;
        logic [15:0]  b;
        logic [15:0]  exp;
    } vec_t;

    function automatic logic [127:0] rep(input logic [7:0] v);
        return {16{v}};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic beat(input logic [127:0] d, input logic [15:0] b,
                        input logic f, input logic l);
        int t;
        logic acc;
        @(negedge clk);
        inputs   = d;
        last_in  = b;
        in_first = f;
        in_last  = l;
        in_valid = 1'b1;
        t = 0;
        acc = 1'b0;
        while (!acc && t < 50) begin
            @(posedge clk);
            acc = in_ready;
            t++;
        end
        if (!acc) chk("beat_accept_timeout", 0, 1);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_got(input int n);
        int t;
        t = 0;
        while (got.size() < n && t < 200) begin
            @(posedge clk);
            t++;
        end
        if (got.size() < n) chk("result_timeout", got.size(), n);
    endtask

    vec_t tbl[6];
    logic [15:0] exp_q[$];
    logic [15:0] exp_sat;
    logic [15:0] hold;
    logic stable, lowrdy;
    int lat;

    initial begin
        tbl[0] = '{{{4{8'h0b}}, {4{8'hff}}, {4{8'h0b}}, {4{8'hff}}}, 16'd3, 16'd83};
        tbl[1] = '{rep(8'h00), 16'd5, 16'd5};
        tbl[2] = '{rep(8'h80), 16'd0, 16'hF800};
        tbl[3] = '{rep(8'h7f), 16'd100, 16'd2132};
        tbl[4] = '{{120'h0, 8'h80}, 16'hFFFF, 16'hFF7F};
        tbl[5] = '{rep(8'h01), 16'h8000, 16'h8010};

        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out", out, 0);
        chk("reset_seq_err", seq_err, 0);
        chk("reset_in_ready", in_ready, 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        foreach (tbl[i]) begin
            got.delete();
            n_err = 0;
            beat(tbl[i].d, tbl[i].b, 1'b1, 1'b1);
            lat = 1;
            #1;
            in_valid = 1'b0;
            while (!out_valid && lat < 20) begin
                @(posedge clk);
                #1;
                lat++;
            end
            chk($sformatf("single%0d_latency", i), lat, 5);
            chk($sformatf("single%0d_out", i), out, tbl[i].exp);
            @(posedge clk);
            #1;
            chk($sformatf("single%0d_seq_err", i), n_err, 0);
        end

        got.delete();
        n_err = 0;
        beat(rep(8'h01), 16'd0, 1'b1, 1'b0);
        beat(rep(8'h01), 16'd0, 1'b0, 1'b0);
        beat(rep(8'h01), 16'd0, 1'b0, 1'b1);
        idle();
        wait_got(1);
        repeat (10) @(posedge clk);
        chk("three_beat_count", got.size(), 1);
        chk("three_beat_out", got[0], 48);
        chk("three_beat_seq_err", n_err, 0);

        got.delete();
        n_err = 0;
        for (int i = 0; i < 17; i++) begin
            beat(rep(8'h7f), 16'd0, i == 0, i == 16);
        end
        idle();
        wait_got(1);
`ifdef ACCUM_TREE_SAT_EN
        exp_sat = 16'h7FFF;
`else
        exp_sat = 16'h86F0;
`endif
        chk("long_vector_out", got[0], exp_sat);
        chk("long_vector_seq_err", n_err, 0);

        got.delete();
        exp_q = '{16'd16, 16'd33, 16'd48, 16'd58, 16'hFFF0, 16'hFFFC};
        fork
            begin
                beat(rep(8'h01), 16'd0, 1'b1, 1'b1);
                beat(rep(8'h02), 16'd1, 1'b1, 1'b1);
                beat(rep(8'h03), 16'd0, 1'b1, 1'b1);
                beat(rep(8'h01), 16'd10, 1'b1, 1'b0);
                beat(rep(8'h02), 16'd0, 1'b0, 1'b1);
                beat(rep(8'hff), 16'd0, 1'b1, 1'b1);
                beat(rep(8'h01), 16'hFFEC, 1'b1, 1'b1);
                idle();
            end
            begin
                int t;
                t = 0;
                @(posedge clk);
                #1;
                while (!out_valid && t < 50) begin
                    @(posedge clk);
                    #1;
                    t++;
                end
                @(negedge clk);
                out_ready = 1'b0;
                hold = out;
                stable = out_valid;
                lowrdy = 1'b1;
                repeat (4) begin
                    @(posedge clk);
                    #1;
                    if (out !== hold || !out_valid) stable = 1'b0;
                    if (in_ready) lowrdy = 1'b0;
                end
                chk("stall_out_stable", stable, 1);
                chk("stall_in_ready_low", lowrdy, 1);
                @(negedge clk);
                out_ready = 1'b1;
            end
        join
        wait_got(6);
        repeat (8) @(posedge clk);
        chk("stall_count", got.size(), 6);
        foreach (exp_q[i]) begin
            chk($sformatf("stall_result%0d", i), got[i], exp_q[i]);
        end

        got.delete();
        n_err = 0;
        beat(rep(8'h05), 16'd100, 1'b1, 1'b0);
        beat(rep(8'h01), 16'd2, 1'b1, 1'b0);
        beat(rep(8'h01), 16'd0, 1'b0, 1'b1);
        idle();
        wait_got(1);
        repeat (3) @(posedge clk);
        chk("restart_out", got[0], 34);
        chk("restart_seq_err", n_err, 1);

        got.delete();
        n_err = 0;
        beat(rep(8'h01), 16'd0, 1'b0, 1'b1);
        idle();
        wait_got(1);
        repeat (3) @(posedge clk);
        chk("orphan_out", got[0], 50);
        chk("orphan_seq_err", n_err, 1);

        beat(rep(8'h09), 16'd0, 1'b1, 1'b0);
        beat(rep(8'h09), 16'd0, 1'b0, 1'b0);
        #1;
        in_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("midreset_out_valid", out_valid, 0);
        chk("midreset_in_ready", in_ready, 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        got.delete();
        n_err = 0;
        beat(rep(8'h00), 16'd7, 1'b1, 1'b1);
        idle();
        wait_got(1);
        repeat (10) @(posedge clk);
        chk("midreset_count", got.size(), 1);
        chk("midreset_out", got[0], 7);
        chk("midreset_seq_err", n_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
